// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data RAM: CPU port A and loader/debug port B.
// A has fixed priority in RUN, B gets a bounded-wait priority slot, PROG gives B sole access.
`timescale 1ns/1ps
module dmem_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_mode,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              prog_active
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_PROG = 1'b1;
    localparam logic       RSEL_A  = 1'b0;
    localparam logic       RSEL_B  = 1'b1;
    localparam logic [3:0] MAX_W   = 4'(MAX_WAIT);

    logic [0:0]        state;
    logic [3:0]        wait_cnt;
    logic              rsel;
    logic              rpend;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (rst_n) begin
            if (state == ST_PROG) begin
                b_gnt = b_req;
            end else if (wait_cnt == MAX_W && b_req) begin
                b_gnt = 1'b1;
            end else begin
                a_gnt = a_req;
                b_gnt = b_req & ~a_req;
            end
        end
    end

    // Grants are already zero in reset, so mem_we cannot fire while rst_n is low.
    assign mem_we      = (a_gnt & a_we) | (b_gnt & b_we);
    assign mem_addr    = b_gnt ? b_addr  : a_addr;
    assign mem_din     = b_gnt ? b_wdata : a_wdata;
    assign prog_active = (state == ST_PROG);

    assign a_rvalid = rpend & (rsel == RSEL_A);
    assign b_rvalid = rpend & (rsel == RSEL_B);
    assign a_rdata  = a_rvalid ? mem_dout : a_rdata_q;
    assign b_rdata  = b_rvalid ? mem_dout : b_rdata_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            wait_cnt  <= 4'd0;
            rsel      <= RSEL_A;
            rpend     <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state <= prog_mode ? ST_PROG : ST_RUN;

            if (prog_mode || b_gnt || !b_req) begin
                wait_cnt <= 4'd0;
            end else if (wait_cnt != MAX_W) begin
                wait_cnt <= wait_cnt + 4'd1;
            end

            rpend <= (a_gnt & ~a_we) | (b_gnt & ~b_we);
            rsel  <= b_gnt ? RSEL_B : RSEL_A;

            if (a_rvalid) a_rdata_q <= mem_dout;
            if (b_rvalid) b_rdata_q <= mem_dout;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter and sequencer for the single-port data RAM (14-bit word address, 32-bit data). It shares the RAM between the CPU load/store port (A) and a secondary master (B), such as the UART program loader or a display/debug reader. It enforces loader exclusivity during programming mode and bounds B's starvation in normal mode. It sits between the CPU memory stage and the RAM instance, and drives the RAM's write enable, address and data directly.

## Interface
- `ADDR_W`, default 14: word address width.
- `DATA_W`, default 32: data width.
- `MAX_WAIT`, default 4: consecutive cycles B may be denied before it gets priority (1..15).

- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `prog_mode` in 1: 1 means the loader owns memory, so A is never granted.
- `a_req` in 1: A access request, held until granted.
- `a_we` in 1: A write (1) or read (0).
- `a_addr` in ADDR_W: A word address.
- `a_wdata` in DATA_W: A write data.
- `a_gnt` out 1: A access accepted this cycle (combinational).
- `a_rvalid` out 1: A read data valid (registered).
- `a_rdata` out DATA_W: A read data.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`: same as A, for B.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out ADDR_W: RAM address.
- `mem_din` out DATA_W: RAM write data.
- `mem_dout` in DATA_W: RAM read data, valid one cycle after the address is presented.
- `prog_active` out 1: the FSM is in PROG.

## Operation
- The FSM has two states, RUN and PROG; reset state is RUN.
  - RUN → PROG when `prog_mode`=1 is sampled.
  - PROG → RUN when `prog_mode`=0 is sampled.
  - `prog_active` = (state==PROG).
- Grant is combinational from the current state, `wait_cnt` and the requests. At most one grant per cycle.
  - PROG: `b_gnt`=`b_req`; `a_gnt`=0.
  - RUN, `wait_cnt`==MAX_WAIT and `b_req`: `b_gnt`=1, `a_gnt`=0.
  - RUN otherwise: A has fixed priority. `a_gnt`=`a_req`; `b_gnt`=`b_req` & ~`a_req`.
- RAM drive:
  - The granted port's addr/wdata/we are muxed to `mem_*`.
  - `mem_we` = granted & we. It is 0 when nothing is granted.
  - With no grant, `mem_addr`/`mem_din` hold A's inputs, which are don't-care.
- `wait_cnt` (4-bit) behaviour:
  - Increments when `b_req` & ~`b_gnt`, saturating at MAX_WAIT.
  - Clears when `b_gnt` or ~`b_req`.
  - Held at 0 in PROG.
- Read return:
  - Registered `rsel` (A/B) and `rpend` are set on a granted read.
  - The next cycle asserts `a_rvalid` or `b_rvalid` for exactly one cycle.
  - `x_rdata` = `mem_dout` while that port's rvalid=1; otherwise `x_rdata` holds its last value.
- Writes produce no rvalid. Write completion is the grant cycle itself.

## Timing
- Reset values:
  - Outputs: `a_rvalid`=0, `b_rvalid`=0, `a_rdata`=0, `b_rdata`=0, `prog_active`=0.
  - Internal state: `rsel`=A, `rpend`=0, `wait_cnt`=0, state RUN.
  - `mem_we`=0 while `rst_n`=0, regardless of requests. Grants are forced to 0 during reset.
- Read latency: grant in cycle N, rvalid and data in cycle N+1.
- Throughput: back-to-back grants every cycle. A read in N followed by a write in N+1 is legal.
- Handshake:
  - A requester keeps req/we/addr/wdata stable until the cycle its gnt=1.
  - It may drop or change its request in the cycle after the grant.
- The `prog_mode` change takes effect the cycle after it is sampled. A read granted to A in the last RUN cycle still returns its rvalid to A in the first PROG cycle.
- Simultaneous requests: A wins unless `wait_cnt`==MAX_WAIT.
- Reset mid-read: the pending rvalid is dropped and is never asserted.

## Test plan
- Reset, then A reads addr 0x0010 holding 0xDEADBEEF → `a_gnt`=1 in cycle N, `a_rvalid`=1 with `a_rdata`=0xDEADBEEF in N+1, `b_rvalid`=0 throughout.
- A and B both request continuously with MAX_WAIT=4 → A granted in 4 consecutive cycles, B granted on the 5th, then A again; `wait_cnt` is back to 0 after B's grant.
- `prog_mode`=1 while B writes 0x00000001..0x00000008 to addresses 0..7 and A requests → `a_gnt` is never asserted. After `prog_mode`=0, A reads addr 5 and gets 0x00000006.
- A reads in cycle N while `prog_mode` rises in N → `a_rvalid` is asserted in N+1 with `prog_active`=1 and `b_gnt` is available in N+1.
- `rst_n` is pulled low asynchronously mid-cycle right after an A read grant → `mem_we`=0 and the rvalids are 0 immediately; after release there is no stale rvalid and the state is RUN.
- A writes 0x12345678 to 0x3FFF, then reads 0x3FFF in the next cycle → the write is accepted, and the read returns 0x12345678 one cycle after its grant. This checks the top address does not wrap.
